// File: rtl/shift_add_seq_multiplier.sv
// Sequential shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH, one multiplier bit per clock (define SIGNED_MODE_EN to add a two's complement mode).
// Latency: out_valid in the (WIDTH+1)th cycle after the accept cycle; initiation interval WIDTH+2.
// Backpressure: in_ready only in IDLE; DONE holds prod and out_valid until out_ready.
module shift_add_seq_multiplier #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SIGNED_MODE_EN
    input  logic                 signed_mode,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;
    logic                 sign;

    logic [WIDTH-1:0]     op_a, op_b;
    logic                 sign_in;
    logic [2*WIDTH-1:0]   acc_sum;
    logic                 last_step;

    // Signed operands are reduced to magnitudes; -2^(WIDTH-1) maps to itself, which
    // read as unsigned is exactly its magnitude.
`ifdef SIGNED_MODE_EN
    always_comb begin
        op_a    = (signed_mode && a[WIDTH-1]) ? -a : a;
        op_b    = (signed_mode && b[WIDTH-1]) ? -b : b;
        sign_in = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end
`else
    always_comb begin
        op_a    = a;
        op_b    = b;
        sign_in = 1'b0;
    end
`endif

    assign acc_sum   = mplier[0] ? (acc + mcand) : acc;
    assign last_step = (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            sign   <= 1'b0;
            prod   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{WIDTH{1'b0}}, op_a};
                        mplier <= op_b;
                        acc    <= '0;
                        cnt    <= '0;
                        sign   <= sign_in;
                    end
                end
                CALC: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_step) begin
                        prod <= sign ? -acc_sum : acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_seq_multiplier.sv
// Randomised self-checking bench for shift_add_seq_multiplier against an arithmetic reference.
module tb_shift_add_seq_multiplier;

    localparam int W = 8;
    localparam int LAT = W + 1;
    localparam int II = W + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a, b;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   prod;
    logic             busy;
`ifdef SIGNED_MODE_EN
    logic             signed_mode;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_add_seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SIGNED_MODE_EN
        .signed_mode(signed_mode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*W-1:0] ref_unsigned(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned p;
        p = int'(x) * int'(y);
        return p[2*W-1:0];
    endfunction

    function automatic logic [2*W-1:0] ref_signed(input logic [W-1:0] x, input logic [W-1:0] y);
        int p;
        p = int'($signed(x)) * int'($signed(y));
        return p[2*W-1:0];
    endfunction

    // Presents one operand pair, then reports cycles to out_valid (accept cycle = 0) and prod.
    task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output logic [2*W-1:0] p, output bit timeout);
        int guard;
        timeout = 1'b0;
        guard = 0;
        while (!in_ready && guard < 200) begin
            step();
            guard++;
        end
        a = x;
        b = y;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        if (!out_valid) timeout = 1'b1;
        p = prod;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
`ifdef SIGNED_MODE_EN
        signed_mode = 1'b0;
`endif
        repeat (3) step();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || prod !== '0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b prod=%h, required 1 0 0 0000",
                     in_ready, out_valid, busy, prod);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [2*W-1:0] p;
        bit to;
        out_ready = 1'b1;
        do_mul(8'd40, 8'd38, lat, p, to);
        checks++;
        if (to || lat !== LAT) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles (timeout=%0b), required %0d", lat, to, LAT);
        end
        checks++;
        if (p !== 16'h05F0) begin
            errors++;
            $display("FAIL basic_prod: got %h, required 05f0", p);
        end
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || prod !== 16'h05F0) begin
            errors++;
            $display("FAIL basic_return_idle: in_ready=%b out_valid=%b prod=%h, required 1 0 05f0",
                     in_ready, out_valid, prod);
        end
    endtask

    task automatic test_corners();
        logic [W-1:0] xs [3] = '{8'hFF, 8'h00, 8'hFF};
        logic [W-1:0] ys [3] = '{8'hFF, 8'hFF, 8'h00};
        int lat;
        logic [2*W-1:0] p;
        bit to;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_mul(xs[i], ys[i], lat, p, to);
            checks++;
            if (to || lat !== LAT || p !== ref_unsigned(xs[i], ys[i])) begin
                errors++;
                $display("FAIL corner_%0d: a=%h b=%h got prod=%h lat=%0d, required prod=%h lat=%0d",
                         i, xs[i], ys[i], p, lat, ref_unsigned(xs[i], ys[i]), LAT);
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        logic [2*W-1:0] p;
        bit to;
        out_ready = 1'b0;
        do_mul(8'd1, 8'd2, lat, p, to);
        checks++;
        if (to || p !== 16'd2) begin
            errors++;
            $display("FAIL bp_prod: got %h (timeout=%0b), required 0002", p, to);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i == 5);
            a = 8'd9;
            b = 8'd9;
            step();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || prod !== 16'd2) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d of 20 cycles lost out_valid/prod=2 or showed in_ready, required 0", bad);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        do_mul(8'd5, 8'd6, lat, p, to);
        checks++;
        if (to || p !== 16'd30 || lat !== LAT) begin
            errors++;
            $display("FAIL bp_next: got prod=%h lat=%0d, required 001e lat=%0d", p, lat, LAT);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int seen;
        int lat;
        logic [2*W-1:0] p;
        bit to;
        out_ready = 1'b1;
        a = 8'd200;
        b = 8'd100;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || prod !== '0) begin
            errors++;
            $display("FAIL midreset_state: in_ready=%b out_valid=%b busy=%b prod=%h, required 1 0 0 0000",
                     in_ready, out_valid, busy, prod);
        end
        seen = 0;
        repeat (15) begin
            step();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset_no_output: out_valid seen %0d times, required 0", seen);
        end
        do_mul(8'd3, 8'd7, lat, p, to);
        checks++;
        if (to || p !== 16'd21) begin
            errors++;
            $display("FAIL midreset_after: got %h, required 0015", p);
        end
        step();
    endtask

    task automatic test_random();
        int lat;
        logic [2*W-1:0] p;
        bit to;
        logic [W-1:0] x, y;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            do_mul(x, y, lat, p, to);
            checks++;
            if (to || lat !== LAT || p !== ref_unsigned(x, y)) begin
                errors++;
                $display("FAIL random_%0d: a=%h b=%h got %h lat=%0d, required %h lat=%0d",
                         i, x, y, p, lat, ref_unsigned(x, y), LAT);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] expq[$];
        logic [2*W-1:0] e;
        int sent, got, cyc, last_cyc;
        logic [W-1:0] x, y;
        out_ready = 1'b1;
        sent = 0;
        got = 0;
        cyc = 0;
        last_cyc = -1;
        in_valid = 1'b1;
        while (got < 10 && cyc < 400) begin
            if (in_ready && sent < 10) begin
                x = W'($urandom);
                y = W'($urandom);
                a = x;
                b = y;
                expq.push_back(ref_unsigned(x, y));
                sent++;
            end else begin
                a = W'($urandom);
                b = W'($urandom);
                if (sent >= 10) in_valid = 1'b0;
            end
            step();
            cyc++;
            if (out_valid) begin
                e = (expq.size() > 0) ? expq.pop_front() : 'x;
                checks++;
                if (prod !== e) begin
                    errors++;
                    $display("FAIL b2b_prod_%0d: got %h, required %h", got, prod, e);
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (cyc - last_cyc != II) begin
                        errors++;
                        $display("FAIL b2b_spacing_%0d: got %0d cycles, required %0d", got, cyc - last_cyc, II);
                    end
                end
                last_cyc = cyc;
                got++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got != 10) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, required 10", got);
        end
        repeat (3) step();
    endtask

`ifdef SIGNED_MODE_EN
    task automatic test_signed();
        logic [W-1:0] xs [3] = '{8'hFD, 8'h80, 8'hFD};
        logic [W-1:0] ys [3] = '{8'h05, 8'h80, 8'h05};
        logic         ms [3] = '{1'b1, 1'b1, 1'b0};
        logic [2*W-1:0] req [3] = '{16'hFFF1, 16'h4000, 16'd1265};
        int lat;
        logic [2*W-1:0] p;
        logic [W-1:0] x, y;
        bit to;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            signed_mode = ms[i];
            do_mul(xs[i], ys[i], lat, p, to);
            checks++;
            if (to || lat !== LAT || p !== req[i]) begin
                errors++;
                $display("FAIL signed_%0d: got %h lat=%0d, required %h lat=%0d", i, p, lat, req[i], LAT);
            end
            step();
        end
        for (int i = 0; i < 6; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            signed_mode = 1'b1;
            do_mul(x, y, lat, p, to);
            checks++;
            if (to || p !== ref_signed(x, y)) begin
                errors++;
                $display("FAIL signed_rand_%0d: a=%h b=%h got %h, required %h", i, x, y, p, ref_signed(x, y));
            end
            step();
        end
        signed_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
`ifdef SIGNED_MODE_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
